// File: rtl/twiddle_addr_seq.sv
// Twiddle-factor ROM read sequencer for a radix-2 FFT: walks every stage/butterfly,
// drives the ROM address and registers the returned word into a valid/ready stream.
// Optional macro TW_DIF_ORDER_EN selects decimation-in-frequency index ordering (default DIT).
module twiddle_addr_seq #(
    parameter int NFFT  = 8,
    parameter int Width = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       Start,
    output logic                       Busy,
    output logic                       Done,
    output logic [Width-1:0]           Address,
    input  logic [Width-1:0]           Data_real,
    input  logic [Width-1:0]           Data_imag,
    output logic [Width-1:0]           Tw_real,
    output logic [Width-1:0]           Tw_imag,
    output logic [$clog2(NFFT)-1:0]    Tw_stage,
    output logic [$clog2(NFFT)-2:0]    Tw_bfly,
    output logic                       Tw_last,
    output logic                       Tw_valid,
    input  logic                       Tw_ready
);

    localparam int L = $clog2(NFFT);
    localparam logic [L-1:0] LAST_STG = L'(L - 1);
    localparam logic [L-2:0] LAST_K   = '1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic             addr_vld_q, addr_vld_d;
    logic [L-1:0]     stg_q, stg_d, stg_nx;
    logic [L-2:0]     k_q, k_d, k_nx;
    logic [Width-1:0] address_q, address_d;
    logic [Width-1:0] tw_real_q, tw_real_d;
    logic [Width-1:0] tw_imag_q, tw_imag_d;
    logic [L-1:0]     tw_stage_q, tw_stage_d;
    logic [L-2:0]     tw_bfly_q, tw_bfly_d;
    logic             tw_last_q, tw_last_d;
    logic             tw_valid_q, tw_valid_d;
    logic             adv_s, last_cnt_s, done_s;

    // Twiddle index for (stage, butterfly); 32-bit arithmetic then truncated to L-1 bits.
    function automatic logic [L-2:0] tw_idx(input logic [L-1:0] s, input logic [L-2:0] kk);
        logic [31:0] mask_v;
        logic [31:0] idx_v;
`ifdef TW_DIF_ORDER_EN
        mask_v = (32'(NFFT) >> (32'(s) + 32'd1)) - 32'd1;
        idx_v  = (32'(kk) & mask_v) << s;
`else
        mask_v = (32'd1 << s) - 32'd1;
        idx_v  = (32'(kk) & mask_v) << (32'(L) - 32'd1 - 32'(s));
`endif
        return (L-1)'(idx_v);
    endfunction

    // Next-state, counter stepping and beat capture.
    always_comb begin
        state_d    = state_q;
        addr_vld_d = addr_vld_q;
        stg_d      = stg_q;
        k_d        = k_q;
        address_d  = address_q;
        tw_real_d  = tw_real_q;
        tw_imag_d  = tw_imag_q;
        tw_stage_d = tw_stage_q;
        tw_bfly_d  = tw_bfly_q;
        tw_last_d  = tw_last_q;
        tw_valid_d = tw_valid_q;

        adv_s      = ~tw_valid_q | Tw_ready;
        last_cnt_s = (stg_q == LAST_STG) && (k_q == LAST_K);
        done_s     = tw_valid_q & Tw_ready & tw_last_q;

        if (k_q == LAST_K) begin
            k_nx   = '0;
            stg_nx = last_cnt_s ? '0 : stg_q + 1'b1;
        end else begin
            k_nx   = k_q + 1'b1;
            stg_nx = stg_q;
        end

        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d    = RUN;
                    stg_d      = '0;
                    k_d        = '0;
                    address_d  = Width'(tw_idx('0, '0));
                    addr_vld_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (adv_s) begin
                    if (addr_vld_q) begin
                        tw_real_d  = Data_real;
                        tw_imag_d  = Data_imag;
                        tw_stage_d = stg_q;
                        tw_bfly_d  = k_q;
                        tw_valid_d = 1'b1;
                        tw_last_d  = last_cnt_s;
                        stg_d      = stg_nx;
                        k_d        = k_nx;
                        address_d  = Width'(tw_idx(stg_nx, k_nx));
                        addr_vld_d = ~last_cnt_s;
                    end else begin
                        tw_valid_d = 1'b0;
                        tw_last_d  = 1'b0;
                    end
                end else begin
                    tw_valid_d = tw_valid_q;
                end
                // The final beat can only be accepted once addr_vld has already dropped.
                if (done_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            addr_vld_q <= 1'b0;
            stg_q      <= '0;
            k_q        <= '0;
            address_q  <= '0;
            tw_real_q  <= '0;
            tw_imag_q  <= '0;
            tw_stage_q <= '0;
            tw_bfly_q  <= '0;
            tw_last_q  <= 1'b0;
            tw_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_vld_q <= addr_vld_d;
            stg_q      <= stg_d;
            k_q        <= k_d;
            address_q  <= address_d;
            tw_real_q  <= tw_real_d;
            tw_imag_q  <= tw_imag_d;
            tw_stage_q <= tw_stage_d;
            tw_bfly_q  <= tw_bfly_d;
            tw_last_q  <= tw_last_d;
            tw_valid_q <= tw_valid_d;
        end
    end

    assign Busy     = (state_q == RUN);
    assign Done     = done_s;
    assign Address  = address_q;
    assign Tw_real  = tw_real_q;
    assign Tw_imag  = tw_imag_q;
    assign Tw_stage = tw_stage_q;
    assign Tw_bfly  = tw_bfly_q;
    assign Tw_last  = tw_last_q;
    assign Tw_valid = tw_valid_q;

endmodule

// File: tb/tb_twiddle_addr_seq.sv
// Directed bench for twiddle_addr_seq: ROM word[i] = i+1 (real), 16-i (imag).
module tb_twiddle_addr_seq;

`ifdef TW_DIF_ORDER_EN
    localparam int NFFT = 16;
`else
    localparam int NFFT = 8;
`endif
    localparam int W    = 16;
    localparam int L    = $clog2(NFFT);
    localparam int HALF = NFFT / 2;
    localparam int NB   = HALF * L;

    logic          CLK = 1'b0;
    logic          RST, Start, Tw_ready;
    logic          Busy, Done, Tw_last, Tw_valid;
    logic [W-1:0]  Address, Data_real, Data_imag, Tw_real, Tw_imag;
    logic [L-1:0]  Tw_stage;
    logic [L-2:0]  Tw_bfly;

    int total = 0;
    int bad   = 0;
    int exp_addr [NB];

    twiddle_addr_seq #(.NFFT(NFFT), .Width(W)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Busy(Busy), .Done(Done),
        .Address(Address), .Data_real(Data_real), .Data_imag(Data_imag),
        .Tw_real(Tw_real), .Tw_imag(Tw_imag), .Tw_stage(Tw_stage),
        .Tw_bfly(Tw_bfly), .Tw_last(Tw_last), .Tw_valid(Tw_valid),
        .Tw_ready(Tw_ready)
    );

    always #5 CLK = ~CLK;

    assign Data_real = Address + 16'd1;
    assign Data_imag = 16'd16 - Address;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic ready_pat(input int rp, input int c);
        if (rp == 0) return 1'b1;
        case ((c - 1) % 6)
            0, 3, 5: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_busy"},  32'(Busy),     32'd0);
        check({tag, "_done"},  32'(Done),     32'd0);
        check({tag, "_valid"}, 32'(Tw_valid), 32'd0);
        check({tag, "_last"},  32'(Tw_last),  32'd0);
        check({tag, "_addr"},  32'(Address),  32'd0);
        check({tag, "_real"},  32'(Tw_real),  32'd0);
        check({tag, "_imag"},  32'(Tw_imag),  32'd0);
        check({tag, "_stage"}, 32'(Tw_stage), 32'd0);
        check({tag, "_bfly"},  32'(Tw_bfly),  32'd0);
    endtask

    // Called between a negedge and the next posedge; Start is raised immediately.
    task automatic run_seq(input int rp, input int busy_start, input int rst_after);
        int   beats = 0;
        int   first = -1;
        bit   prev_stall = 1'b0;
        bit   fin = 1'b0;
        bit   exp_done;
        int   a;
        Start = 1'b1;
        for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
            @(negedge CLK);
            Start = 1'b0;
            if (rst_after >= 0 && beats == rst_after) begin
                RST = 1'b1;
                Tw_ready = 1'b1;
                @(negedge CLK);
                #1;
                check_zero("midrst");
                RST = 1'b0;
                return;
            end
            Tw_ready = ready_pat(rp, cyc);
            if (busy_start != 0 && Tw_valid && (beats == 4 || (Tw_last && Tw_ready)))
                Start = 1'b1;
            #1;
            if (cyc == 1) begin
                check("busy_after_start", 32'(Busy), 32'd1);
                check("valid_after_start", 32'(Tw_valid), 32'd0);
            end
            if (prev_stall) check("stall_hold", 32'(Tw_valid), 32'd1);
            if (Tw_valid && first < 0) begin
                first = cyc;
                check("first_valid_cyc", 32'(cyc), 32'd2);
            end
            exp_done = 1'b0;
            if (Tw_valid) begin
                if (beats < NB) begin
                    a = exp_addr[beats];
                    check("tw_real",  32'(Tw_real),  32'(a + 1));
                    check("tw_imag",  32'(Tw_imag),  32'(16 - a));
                    check("tw_stage", 32'(Tw_stage), 32'(beats / HALF));
                    check("tw_bfly",  32'(Tw_bfly),  32'(beats % HALF));
                    check("tw_last",  32'(Tw_last),  32'(beats == NB - 1));
                end else begin
                    check("extra_beat", 32'(beats), 32'(NB - 1));
                end
                if (Tw_ready) begin
                    exp_done = (beats == NB - 1);
                    beats++;
                end
            end
            if (Done || exp_done) check("done", 32'(Done), 32'(exp_done));
            prev_stall = Tw_valid && !Tw_ready;
            if (exp_done) fin = 1'b1;
        end
        if (!fin) begin
            check("timeout_beats", 32'(beats), 32'(NB));
        end else begin
            @(negedge CLK);
            Start = 1'b0;
            #1;
            check("busy_fall", 32'(Busy), 32'd0);
            check("valid_fall", 32'(Tw_valid), 32'd0);
        end
        check("beat_count", 32'(beats), 32'(NB));
    endtask

    initial begin
`ifdef TW_DIF_ORDER_EN
        exp_addr = '{0,1,2,3,4,5,6,7, 0,2,4,6,0,2,4,6, 0,4,0,4,0,4,0,4, 0,0,0,0,0,0,0,0};
`else
        exp_addr = '{0,0,0,0, 0,2,0,2, 0,1,2,3};
`endif
        RST = 1'b1;
        Start = 1'b0;
        Tw_ready = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        check_zero("reset");
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        check("idle_busy", 32'(Busy), 32'd0);

        run_seq(0, 0, -1);   // basic, ready high
        run_seq(1, 0, -1);   // backpressure, starts the cycle after Busy fell
        run_seq(0, 1, -1);   // Start while busy at beat 5 and in the Done cycle
        run_seq(0, 0, 6);    // reset after beat 6
        run_seq(0, 0, -1);   // full run after reset
        run_seq(0, 0, -1);   // back-to-back runs
        run_seq(1, 1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/twiddle_addr_seq.md
Name: twiddle_addr_seq

Overview:
- Sequencer that reads the twiddle-factor ROM for a radix-2 NFFT-point FFT.
- Walks every stage and butterfly and drives the ROM `Address`.
- Captures the combinational `Data_real`/`Data_imag` return into a registered valid/ready stream for the butterfly datapath.
- Provides per-beat stage and butterfly tags, a last-beat flag and a done pulse.

Parameters:
- NFFT, 8, number of FFT points; power of two, 4 or more. L = log2(NFFT).
- Width, 16, ROM address and data word width.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  synchronous active-high reset
- Start  input  1  one-cycle request to run a full twiddle sequence
- Busy  output  1  high from Start acceptance through the Done cycle
- Done  output  1  one-cycle pulse when the final beat is accepted
- Address  output  Width  ROM address; twiddle index, zero-extended
- Data_real  input  Width  ROM real word for Address (combinational)
- Data_imag  input  Width  ROM imaginary word for Address (combinational)
- Tw_real  output  Width  registered twiddle, real part
- Tw_imag  output  Width  registered twiddle, imaginary part
- Tw_stage  output  L  stage index of the current beat
- Tw_bfly  output  L-1  butterfly index k within the stage
- Tw_last  output  1  high on the final beat (stage L-1, k = NFFT/2-1)
- Tw_valid  output  1  beat valid
- Tw_ready  input  1  consumer ready

Behaviour:
- Reset: RST high at a clock edge clears all state and outputs.
  - Busy, Done, Tw_valid and Tw_last go to 0.
  - Address, Tw_real, Tw_imag, Tw_stage and Tw_bfly go to 0.
  - Internal counters go to 0 and the FSM goes to IDLE.
  - RST overrides everything, including mid-sequence; a partial sequence is discarded and not resumed.
- FSM states: IDLE, RUN.
  - IDLE to RUN on Start when Busy is 0. Start while Busy is 1 is ignored, including in the Done cycle.
  - RUN to IDLE when the last beat is accepted (Tw_valid & Tw_ready & Tw_last).
  - Done pulses in that same cycle; Busy falls the following cycle.
- Counters: stg runs 0..L-1 and k runs 0..NFFT/2-1, with k innermost. k wraps to 0 and stg increments.
- Index (DIT, default): idx(stg,k) = (k & ((1<<stg)-1)) << (L-1-stg). Address = idx, zero-extended to Width.
- Start acceptance edge: Address <= idx(0,0); internal addr_vld <= 1.
- Advance condition: adv = !Tw_valid | Tw_ready. When adv and addr_vld:
  - Tw_real <= Data_real and Tw_imag <= Data_imag.
  - Tw_stage <= stg, Tw_bfly <= k, Tw_valid <= 1.
  - Tw_last <= (stg == L-1 && k == NFFT/2-1).
  - Counters and Address step to the next index. If the captured beat was the last, addr_vld <= 0.
- When adv and !addr_vld: Tw_valid <= 0.
- When !adv (stall): Tw_*, Address and counters all hold.
- Latency: Start edge E0 puts Address valid after E0; the first Tw_valid is after E1.
- Throughput: with Tw_ready held high, one beat per cycle; (NFFT/2)*L beats total, contiguous.
- Tw_ready may toggle arbitrarily. The stream has no skipped and no duplicated beats.
- Tw_valid is never dropped without acceptance.

Optional Feature:
- Macro: TW_DIF_ORDER_EN.
- Defined: decimation-in-frequency ordering, idx(stg,k) = (k & ((NFFT>>(stg+1))-1)) << stg. For NFFT=8, stage 0 gives 0,1,2,3 and stage 2 gives 0,0,0,0.
- Undefined: the DIT formula above.
- Handshake, counts, tags and latency are identical in both builds.

Test Plan:
- Basic DIT sequence: NFFT=8, ROM word[i]=i+1 (real) and 16-i (imag), Tw_ready=1, Start pulse.
  - Exactly 12 beats.
  - Addresses 0,0,0,0 / 0,2,0,2 / 0,1,2,3; Tw_real 1,1,1,1 / 1,3,1,3 / 1,2,3,4.
  - Tw_last and Done on beat 12 only; first Tw_valid 2 cycles after Start.
- Backpressure: Tw_ready follows the pattern 1,0,0,1,0,1... Same 12 beats, same order, no duplicates; outputs stable while stalled.
- Start while busy: second Start at beat 5 and in the Done cycle → both ignored; exactly 12 beats; Busy falls the cycle after Done.
- Reset mid-operation: RST after beat 6 → all outputs 0 the next cycle. A new Start then yields a full 12-beat sequence from stage 0, k=0.
- DIF build: TW_DIF_ORDER_EN with NFFT=16 → stage 0 addresses 0..7, stage 3 all 0; 32 beats total.
- Back-to-back runs: Start the cycle after Busy falls → second run begins immediately; results identical to the first run.
